// File: rtl/unidade_controle_exp4_if.sv
// Control/status bundle between the sequence-game FSM and its counter/comparator datapath.
// jogada is a raw level and the FSM finds its rising edge. All other inputs are levels that the FSM samples only in the states that use them.
interface unidade_controle_exp4_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zera;
  logic       conta;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fim,
    output zera, conta, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fim,
    input  zera, conta, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_exp4.sv
// Sequence-game controller: steps contador_163 and checks each jogada against comparador_85.
// Optional ESPERA timeout is built when the macro TIMEOUT_EN is defined.
module unidade_controle_exp4 #(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic                     clock,
  input  logic                     reset,
  unidade_controle_exp4_if.master  bus
);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h3,
    COMPARA  = 4'h4,
    PROXIMO  = 4'h5,
    ACERTO   = 4'hA,
    ERRO     = 4'hE
  } estado_t;

  estado_t estado, proximo;
  logic    jogada_d;
  logic    jogada_ed;
  logic    fim_espera;

  if (TIMEOUT_CICLOS < 1) begin : g_param_check
    $error("TIMEOUT_CICLOS must be at least 1");
  end

  // jogada_d resets high so a button held through reset does not count as a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      jogada_d <= 1'b1;
    end else begin
      estado   <= proximo;
      jogada_d <= bus.jogada;
    end
  end

  assign jogada_ed = bus.jogada & ~jogada_d;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] timer;
  logic          timeout_q;

  // The timer restarts on every entry to ESPERA because any other state clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (estado == ESPERA) timer <= timer + TW'(1);
      else                  timer <= '0;
      if (estado == ESPERA && proximo == ERRO)      timeout_q <= 1'b1;
      else if (estado == ERRO && proximo != ERRO)   timeout_q <= 1'b0;
    end
  end

  assign fim_espera  = (estado == ESPERA) && (timer == TW'(TIMEOUT_CICLOS - 1));
  assign bus.timeout = timeout_q;
`else
  assign fim_espera  = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:  if (bus.iniciar) proximo = PREPARA;
      PREPARA:  proximo = ESPERA;
      ESPERA: begin
        if (jogada_ed)       proximo = REGISTRA;
        else if (fim_espera) proximo = ERRO;
      end
      REGISTRA: proximo = COMPARA;
      COMPARA:  proximo = bus.igual ? PROXIMO : ERRO;
      PROXIMO:  proximo = bus.fim ? ACERTO : ESPERA;
      ACERTO,
      ERRO:     if (bus.iniciar) proximo = PREPARA;
      default:  proximo = INICIAL;
    endcase
  end

  // conta is suppressed on the last step so the counter parks at F instead of wrapping.
  assign bus.zera      = (estado == PREPARA);
  assign bus.conta     = (estado == PROXIMO) && !bus.fim;
  assign bus.pronto    = (estado == ACERTO) || (estado == ERRO);
  assign bus.acertou   = (estado == ACERTO);
  assign bus.errou     = (estado == ERRO);
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_exp4.sv
// Directed bench for unidade_controle_exp4 with a behavioural counter/comparator datapath.
module tb_unidade_controle_exp4;

  localparam int unsigned TO_CICLOS = 8;

  // Output flag order: {zera, conta, pronto, acertou, errou, timeout}
  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [5:0] ZR = 6'b100000;
  localparam logic [5:0] CT = 6'b010000;
  localparam logic [5:0] AC = 6'b001100;
  localparam logic [5:0] ER = 6'b001010;
  localparam logic [5:0] TO = 6'b001011;

  typedef struct {
    logic       rst;
    logic       ini;
    logic       jog;
    logic [3:0] ch;
    logic [3:0] est;
    logic [5:0] fl;
    string      nm;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic [3:0] cnt = 4'h0;
  int         checks = 0;
  int         errors = 0;
  int         conta_pulses = 0;
  logic [9:0] exp_q[$];
  vec_t       tbl[$];

  unidade_controle_exp4_if bus();

  unidade_controle_exp4 #(.TIMEOUT_CICLOS(TO_CICLOS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / datapath model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.zera)       cnt <= 4'h0;
    else if (bus.conta) cnt <= cnt + 4'd1;
  end

  assign bus.igual = (cnt == chaves);
  assign bus.fim   = (cnt == 4'hF);

  // driver + scoreboard
  task automatic apply(input logic r, input logic i, input logic j, input logic [3:0] ch,
                       input logic [3:0] est, input logic [5:0] fl, input string nm);
    logic [9:0] got;
    logic [9:0] expv;
    reset       = r;
    bus.iniciar = i;
    bus.jogada  = j;
    chaves      = ch;
    exp_q.push_back({est, fl});
    @(posedge clock);
    #1;
    got  = {bus.db_estado, bus.zera, bus.conta, bus.pronto, bus.acertou, bus.errou, bus.timeout};
    expv = exp_q.pop_front();
    if (bus.conta === 1'b1) conta_pulses++;
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got estado=%h flags=%b, required estado=%h flags=%b",
               nm, got[9:6], got[5:0], expv[9:6], expv[5:0]);
    end
  endtask

  task automatic add(input logic r, input logic i, input logic j, input logic [3:0] ch,
                     input logic [3:0] est, input logic [5:0] fl, input string nm);
    tbl.push_back('{r, i, j, ch, est, fl, nm});
  endtask

  task automatic jogar(input logic [3:0] val, input logic ultimo);
    apply(1'b0, 1'b0, 1'b1, val, 4'h3, F0, "g_registra");
    apply(1'b0, 1'b0, 1'b0, val, 4'h4, F0, "g_compara");
    if (ultimo) begin
      apply(1'b0, 1'b0, 1'b0, val, 4'h5, F0, "g_proximo_last");
      apply(1'b0, 1'b0, 1'b0, val, 4'hA, AC, "g_acerto");
    end else begin
      apply(1'b0, 1'b0, 1'b0, val, 4'h5, CT, "g_proximo");
      apply(1'b0, 1'b0, 1'b0, val, 4'h2, F0, "g_espera");
    end
  endtask

  initial begin
    reset = 1'b1; bus.iniciar = 1'b0; bus.jogada = 1'b0; chaves = 4'h0;

    // reset and start
    add(1, 0, 0, 4'h0, 4'h0, F0, "reset");
    add(0, 0, 0, 4'h0, 4'h0, F0, "inicial_idle");
    add(0, 1, 0, 4'h0, 4'h1, ZR, "prepara");
    add(0, 0, 0, 4'h0, 4'h2, F0, "espera");
    add(0, 0, 0, 4'h0, 4'h2, F0, "espera_hold");
    // three correct entries, then chaves=7 against counter=3
    for (int c = 0; c < 3; c++) begin
      add(0, 0, 1, 4'(c), 4'h3, F0, "registra");
      add(0, 0, 0, 4'(c), 4'h4, F0, "compara");
      add(0, 0, 0, 4'(c), 4'h5, CT, "proximo");
      add(0, 0, 0, 4'(c), 4'h2, F0, "espera_next");
    end
    add(0, 0, 1, 4'h7, 4'h3, F0, "mm_registra");
    add(0, 0, 0, 4'h7, 4'h4, F0, "mm_compara");
    add(0, 0, 0, 4'h7, 4'hE, ER, "mm_erro");
    add(0, 0, 0, 4'h7, 4'hE, ER, "mm_hold");
    add(0, 0, 1, 4'h7, 4'hE, ER, "mm_jogada_ignored");
    add(0, 1, 0, 4'h7, 4'h1, ZR, "mm_restart");
    add(0, 0, 0, 4'h0, 4'h2, F0, "mm_espera");
    // jogada held for 10 cycles: one step only
    add(0, 0, 1, 4'h0, 4'h3, F0, "held_registra");
    add(0, 0, 1, 4'h0, 4'h4, F0, "held_compara");
    add(0, 0, 1, 4'h0, 4'h5, CT, "held_proximo");
    for (int k = 0; k < 7; k++) add(0, 0, 1, 4'h0, 4'h2, F0, "held_espera");
    add(0, 0, 0, 4'h1, 4'h2, F0, "held_release");
    // extra pulse during COMPARA is ignored
    add(0, 0, 1, 4'h1, 4'h3, F0, "pc_registra");
    add(0, 0, 0, 4'h1, 4'h4, F0, "pc_compara");
    add(0, 0, 1, 4'h1, 4'h5, CT, "pc_pulse_in_compara");
    add(0, 0, 0, 4'h1, 4'h2, F0, "pc_espera");
    add(0, 0, 0, 4'h1, 4'h2, F0, "pc_no_extra");
    // reset while conta is high, reset+iniciar, iniciar ignored in ESPERA
    add(0, 0, 1, 4'h2, 4'h3, F0, "r_registra");
    add(0, 0, 0, 4'h2, 4'h4, F0, "r_compara");
    add(0, 0, 0, 4'h2, 4'h5, CT, "r_proximo");
    add(1, 0, 0, 4'h2, 4'h0, F0, "rst_in_proximo");
    add(0, 0, 0, 4'h2, 4'h0, F0, "after_reset");
    add(1, 1, 0, 4'h0, 4'h0, F0, "rst_and_iniciar");
    add(0, 0, 0, 4'h0, 4'h0, F0, "inicial_hold");
    add(0, 1, 0, 4'h0, 4'h1, ZR, "prepara2");
    add(0, 1, 0, 4'h0, 4'h2, F0, "prepara_to_espera");
    add(0, 1, 0, 4'h0, 4'h2, F0, "iniciar_ignored");
    add(1, 0, 1, 4'h0, 4'h0, F0, "rst_jog_held");
    add(0, 1, 1, 4'h0, 4'h1, ZR, "held_prepara");
    add(0, 0, 1, 4'h0, 4'h2, F0, "held_espera2");
    add(0, 0, 1, 4'h0, 4'h2, F0, "held_no_edge");
    add(0, 0, 0, 4'h0, 4'h2, F0, "held_dropped");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].rst, tbl[i].ini, tbl[i].jog, tbl[i].ch, tbl[i].est, tbl[i].fl, tbl[i].nm);

    // full game 0..F
    apply(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, F0, "g_reset");
    conta_pulses = 0;
    apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, ZR, "g_prepara");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "g_espera0");
    for (int k = 0; k < 16; k++) jogar(4'(k), k == 15);
    checks++;
    if (conta_pulses != 15) begin
      errors++;
      $display("FAIL g_conta_pulses: got %0d, required 15", conta_pulses);
    end
    apply(1'b0, 1'b0, 1'b0, 4'h3, 4'hA, AC, "acerto_hold");
    apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, ZR, "acerto_restart");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "acerto_espera");

`ifdef TIMEOUT_EN
    apply(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, F0, "to_reset");
    apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, ZR, "to_prepara");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "to_espera");
    for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "to_wait");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'hE, TO, "to_erro");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'hE, TO, "to_hold");
    apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, ZR, "to_clear");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "to_espera2");
    for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "to_wait2");
    apply(1'b0, 1'b0, 1'b1, 4'h0, 4'h3, F0, "to_jogada_wins");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h4, F0, "to_compara");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h5, CT, "to_proximo");
    apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "to_espera3");
`else
    apply(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, F0, "nt_reset");
    apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, ZR, "nt_prepara");
    for (int k = 0; k < 100; k++) apply(1'b0, 1'b0, 1'b0, 4'h0, 4'h2, F0, "nt_espera_forever");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
